// File: rtl/gap_pkg.sv
// rtl/gap_pkg.sv - shared types and helpers for the global average pooling stage
package gap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_SCALE,
        ST_WRITE,
        ST_FIN
    } state_t;

    // Accumulator width that cannot wrap when summing pix full-scale signed elements
    function automatic int acc_width(input int data_width, input int pix);
        return data_width + $clog2(pix) + 1;
    endfunction

    // Clamp a signed value into the range of a width-bit signed number
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/gap_scale_sat.sv
// rtl/gap_scale_sat.sv - reciprocal multiply, round-half-up and saturate of a channel sum
module gap_scale_sat #(
    parameter int ACC_W       = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int RECIP_MULT  = 1170,
    parameter int RECIP_SHIFT = 16
) (
    input  logic signed [ACC_W-1:0]      i_acc,
    output logic signed [DATA_WIDTH-1:0] o_data
);
    import gap_pkg::*;

    // One extra bit keeps the unsigned multiplier positive inside a signed product
    localparam int PROD_W = ACC_W + $clog2(RECIP_MULT + 1) + 1;
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) <<< (RECIP_SHIFT - 1);

    logic signed [PROD_W-1:0] w_acc_ext;
    logic signed [PROD_W-1:0] w_mult;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_rnd;
    logic signed [PROD_W-1:0] w_shift;

    assign w_acc_ext = PROD_W'(i_acc);
    assign w_mult    = PROD_W'(RECIP_MULT);
    assign w_prod    = w_acc_ext * w_mult;
    assign w_rnd     = w_prod + HALF;
    // Arithmetic shift floors toward minus infinity, so negative averages round half-up too
    assign w_shift   = w_rnd >>> RECIP_SHIFT;
    assign o_data    = DATA_WIDTH'(sat_s(64'(w_shift), DATA_WIDTH));

endmodule

// File: rtl/global_avg_pool.sv
// rtl/global_avg_pool.sv - per-channel global average pooling from fmap BRAM into pooled-vector BRAM
module global_avg_pool #(
    parameter int CHANNELS    = 128,
    parameter int HEIGHT      = 7,
    parameter int WIDTH       = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int RELU_EN     = 1,
    parameter int RECIP_MULT  = 1170,
    parameter int RECIP_SHIFT = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [$clog2(CHANNELS*HEIGHT*WIDTH)-1:0]   fmap_addr,
    input  logic signed [DATA_WIDTH-1:0]               fmap_data,
    output logic [$clog2(CHANNELS)-1:0]                pool_addr,
    output logic signed [DATA_WIDTH-1:0]               pool_data,
    output logic                                       pool_we
);
    import gap_pkg::*;

    localparam int PIX   = HEIGHT * WIDTH;
    localparam int ACC_W = acc_width(DATA_WIDTH, PIX);
    localparam int AW    = $clog2(CHANNELS * PIX);
    localparam int CW    = $clog2(CHANNELS);
    localparam int PW    = $clog2(PIX);

    state_t                         r_state;
    state_t                         w_next;
    logic [CW-1:0]                  r_ch;
    logic [PW-1:0]                  r_pix;
    logic signed [ACC_W-1:0]        r_acc;
    logic [AW-1:0]                  r_fmap_addr;
    logic [CW-1:0]                  r_pool_addr;
    logic signed [DATA_WIDTH-1:0]   r_pool_data;
    logic signed [ACC_W-1:0]        w_elem;
    logic signed [DATA_WIDTH-1:0]   w_scaled;
    logic                           w_last_pix;
    logic                           w_last_ch;

    assign w_last_pix = (r_pix == PW'(PIX - 1));
    assign w_last_ch  = (r_ch == CW'(CHANNELS - 1));
    assign w_elem     = (RELU_EN != 0 && fmap_data[DATA_WIDTH-1]) ? '0 : ACC_W'(fmap_data);

    assign fmap_addr  = r_fmap_addr;
    assign pool_addr  = r_pool_addr;
    assign pool_data  = r_pool_data;

    gap_scale_sat #(
        .ACC_W       (ACC_W),
        .DATA_WIDTH  (DATA_WIDTH),
        .RECIP_MULT  (RECIP_MULT),
        .RECIP_SHIFT (RECIP_SHIFT)
    ) u_scale_sat (
        .i_acc  (r_acc),
        .o_data (w_scaled)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; busy is already low in the done cycle
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        pool_we = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                busy = 1'b1;
                if (w_last_pix) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy   = 1'b1;
                w_next = ST_SCALE;
            end
            ST_SCALE: begin
                busy   = 1'b1;
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy    = 1'b1;
                pool_we = 1'b1;
                w_next  = w_last_ch ? ST_FIN : ST_READ;
            end
            ST_FIN: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: address generation, accumulation and result registers.
    // The fmap is channel-major and contiguous, so the next address is always the last one plus one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch        <= '0;
            r_pix       <= '0;
            r_acc       <= '0;
            r_fmap_addr <= '0;
            r_pool_addr <= '0;
            r_pool_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ch        <= '0;
                        r_pix       <= '0;
                        r_acc       <= '0;
                        r_fmap_addr <= '0;
                    end
                end
                ST_READ: begin
                    // Data for pixel r_pix-1 is on the bus; nothing is pending in the first read cycle
                    if (r_pix != '0) begin
                        r_acc <= r_acc + w_elem;
                    end
                    if (!w_last_pix) begin
                        r_pix       <= r_pix + PW'(1);
                        r_fmap_addr <= r_fmap_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    r_acc <= r_acc + w_elem;
                end
                ST_SCALE: begin
                    r_pool_data <= w_scaled;
                    r_pool_addr <= r_ch;
                end
                ST_WRITE: begin
                    r_acc <= '0;
                    if (!w_last_ch) begin
                        r_ch        <= r_ch + CW'(1);
                        r_pix       <= '0;
                        r_fmap_addr <= r_fmap_addr + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/global_avg_pool.md
Name: global_avg_pool

Overview:
- Stage directly downstream of the pointwise conv stage.
- Reads the pointwise output feature map (OUT_CHANNELS x HEIGHT x WIDTH, channel-major) from its BRAM through a 1-cycle-latency read port.
- Per channel: applies optional ReLU per element, sums all pixels, scales by a fixed-point reciprocal of the pixel count, and saturates.
- Writes one value per channel into a pooled-vector BRAM that feeds the dense classifier.

Parameters:
- CHANNELS, 128, number of channels to pool (equals pointwise OUT_CHANNELS).
- HEIGHT, 7, feature-map rows.
- WIDTH, 8, feature-map columns.
- DATA_WIDTH, 8, signed element width for input and output.
- RELU_EN, 1, 1 = clamp negative inputs to 0 before summing.
- RECIP_MULT, 1170, unsigned reciprocal numerator: floor(2^RECIP_SHIFT / (HEIGHT*WIDTH)).
- RECIP_SHIFT, 16, reciprocal fractional bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a pooling pass; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until the done cycle
- done  out  1  one-cycle pulse when the final channel has been written
- fmap_addr  out  clog2(CHANNELS*HEIGHT*WIDTH)  read address; value = ch*HEIGHT*WIDTH + pix
- fmap_data  in  DATA_WIDTH  signed read data, valid 1 cycle after its address
- pool_addr  out  clog2(CHANNELS)  write address = ch
- pool_data  out  DATA_WIDTH  pooled signed result
- pool_we  out  1  write strobe, one cycle per channel

Behaviour:
- Reset values:
  - All outputs 0, state IDLE, ch = 0, pix = 0, acc = 0.
  - Reset mid-pass aborts immediately. No further writes occur, and done is not pulsed.
- PIX = HEIGHT*WIDTH.
- ACC_W = DATA_WIDTH + clog2(PIX) + 1, signed.
- Product width = ACC_W + clog2(RECIP_MULT+1) + 1.
- States: IDLE, READ, DRAIN, SCALE, WRITE, FIN.
- IDLE:
  - start=1 -> READ; set ch=0, pix=0, acc=0; drive fmap_addr for (ch, pix=0).
  - start while busy is ignored.
- READ: each cycle
  - If a read issued last cycle: acc += relu(fmap_data), where relu(x) = (RELU_EN && x<0) ? 0 : x, sign-extended to ACC_W.
  - Issue the next address (pix+1). After address PIX-1 has been issued -> DRAIN.
- DRAIN: accumulate the final element (PIX accumulates in total) -> SCALE.
- SCALE:
  - avg = (acc*RECIP_MULT + 2^(RECIP_SHIFT-1)) >>> RECIP_SHIFT, arithmetic shift (floor).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and register the result into pool_data -> WRITE.
- WRITE:
  - pool_we=1 for exactly this cycle; pool_addr=ch; acc cleared.
  - If ch==CHANNELS-1 -> FIN.
  - Else ch++, pix=0, drive the fmap_addr for the new channel -> READ.
- FIN: done=1 for one cycle, busy drops in the same cycle -> IDLE.
- Latency from start-accept edge to the done pulse: CHANNELS*(PIX+3)+1 cycles. Defaults give 7553.
- fmap_addr holds its last value when not issuing. pool_addr and pool_data hold their values between writes.
- Overflow: ACC_W guarantees no wrap for PIX elements at full-scale negative or positive input.

Decomposition:
- Package gap_pkg holds:
  - state_t enum;
  - function acc_width(DATA_WIDTH, PIX);
  - function sat_s(value, width), shared with other stages that quantise.
- One sub-module, gap_scale_sat: reciprocal multiply, round, and saturate.
  - Combinational, instantiated once, its output registered in SCALE.
  - Unit-testable in isolation.

Test Plan:
- All 56 elements of every channel = 1 -> each pool_data = 1 (56*1170+32768 >>16 = 1). 128 writes at addr 0..127, done once, 7553 cycles after start.
- All elements = 100 -> pool_data = 100. All elements = 127 -> 127, no saturation.
- All elements = -5: with RELU_EN=1 -> 0; with RELU_EN=0 -> -5 (floor(-294832/65536) = -5).
- Ramp per channel, element p = p-28: RELU_EN=1 -> 7 (sum 378); RELU_EN=0 -> 0 (sum -28).
- Assert rst_n low during channel 40 READ -> outputs 0 immediately, no pool_we, no done. A new start afterwards completes a full pass correctly.
- Pulse start again while busy, and hold start high across FIN -> the second pulse is ignored. Held-high start begins a new pass only from IDLE, with pool_we counts of exactly 128 per pass.
